mc_control_fsm: RTL and testbench
=================================

Name: mc_control_fsm

Overview:
- Multicycle successor to the single-cycle MIPS control decoder; drives the datapath of the multicycle core (PC, IR, register file, ALU, unified memory).
- Moore-style FSM sequencing FETCH/DECODE/EXECUTE/MEM/WRITEBACK per opcode.
- Adds J, a memory ready handshake, illegal-opcode trapping and an external stall.
- Sits between the IR opcode field and all datapath muxes/enables.

Parameters:
- OP_W, 6, opcode width.
- ALUOP_W, 3, width of ALUOP bus (encodings below occupy 3 LSBs, upper bits zero).
- MEM_WAIT_MAX, 15, max cycles waiting on mem_ready before raising mem_timeout (0 = never time out).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- opCode  in  OP_W  IR[31:26], valid from DECODE onward.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completed current read/write this cycle.
- stall  in  1  freeze FSM in current state (all enables forced 0).
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegDst, RegWrite, ALUSrcA  out  1 each  datapath controls.
- ALUSrcB  out  2  00 regB, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
- PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- ALUOP  out  ALUOP_W  000 R-funct, 010 add, 110 sub, 011 and, 001 or, 111 slt.
- illegal_op, mem_timeout  out  1 each  sticky error flags.
- state  out  4  current state code (debug).

Behaviour:
- States (code): IDLE 0, FETCH 1, DECODE 2, EXEC_R 3, EXEC_I 4, MEM_ADDR 5, MEM_RD 6, MEM_WB 7, MEM_WR 8, REG_WB 9, BRANCH 10, JUMP 11, TRAP 12.
- rst=1 at edge: state<=IDLE, illegal_op<=0, mem_timeout<=0, wait counter<=0. In IDLE every output 0. IDLE->FETCH on first edge with rst=0.
- Outputs are decoded from state only, except the ready-qualified enables below.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOP=010, PCSource=00; IRWrite=PCWrite=mem_ready. Stay while mem_ready=0; ->DECODE when 1.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOP=010 (branch target precompute). Next by opCode: 000000->EXEC_R; 001000/001010/001100/001101->EXEC_I; 100011/101011->MEM_ADDR; 000100->BRANCH; 000010->JUMP; anything else->TRAP.
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOP=000 -> REG_WB.
- EXEC_I: ALUSrcA=1, ALUSrcB=10, ALUOP 010 addi, 111 slti, 011 andi, 001 ori -> REG_WB.
- REG_WB: RegWrite=1, MemToReg=0, RegDst=1 if opCode=000000 else 0 -> FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOP=010 -> MEM_RD (LW) or MEM_WR (SW).
- MEM_RD: MemRead=1, IorD=1; stay until mem_ready, then ->MEM_WB. MEM_WB: RegWrite=1, MemToReg=1, RegDst=0 -> FETCH.
- MEM_WR: MemWrite=1, IorD=1; stay until mem_ready, then ->FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOP=110, PCWriteCond=1, PCSource=01 -> FETCH (datapath ANDs PCWriteCond with zero; zero is not used by the FSM).
- JUMP: PCWrite=1, PCSource=10 -> FETCH.
- TRAP: illegal_op<=1; all enables 0; remain in TRAP until rst.
- Wait counter: increments each cycle in FETCH/MEM_RD/MEM_WR with mem_ready=0; cleared on state exit. When MEM_WAIT_MAX!=0 and counter reaches MEM_WAIT_MAX: mem_timeout<=1, ->TRAP.
- stall=1: state, counter and flags hold; all write/read enables (PCWrite, PCWriteCond, IRWrite, RegWrite, MemRead, MemWrite) forced 0; mux selects unchanged. stall has priority over mem_ready. rst has priority over stall.
- Latency with mem_ready=1 and stall=0 (cycles FETCH to next FETCH): R/I-arith 4, LW 5, SW 4, BEQ 3, J 3.
- rst mid-instruction (including inside a memory wait) aborts with no further enables asserted after that edge.

Test Plan:
- rst 2 cycles, then opCode=000000, mem_ready=1 -> states 0,1,2,3,9,1; RegWrite=1, RegDst=1 only in state 9.
- LW (100011), mem_ready low for 3 cycles in MEM_RD -> MemRead=1,IorD=1 held 4 cycles; MEM_WB asserts RegWrite=1, MemToReg=1; total 8 cycles.
- BEQ (000100) -> state 10 with ALUOP=110, PCWriteCond=1, PCSource=01; back to FETCH after 3 cycles.
- opCode=111111 -> DECODE->TRAP, illegal_op=1 sticky, all enables 0 until rst clears flag.
- mem_ready=0 held in FETCH, MEM_WAIT_MAX=15 -> mem_timeout=1 and state=12 after 15 cycles in FETCH; IRWrite never asserted.
- stall=1 for 2 cycles in EXEC_I (ORI 001101), then rst asserted in REG_WB -> state holds 4 during stall, ALUOP=001; no RegWrite after rst edge; state=0.

Source files
------------

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control sequencer: one state per datapath phase, with memory
// ready handshake, wait timeout, external stall and illegal-opcode trapping.
module mc_control_fsm #(
  parameter int OP_W         = 6,
  parameter int ALUOP_W      = 3,
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OP_W-1:0]    opCode,
  input  logic               zero,
  input  logic               mem_ready,
  input  logic               stall,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MemToReg,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSource,
  output logic [ALUOP_W-1:0] ALUOP,
  output logic               illegal_op,
  output logic               mem_timeout,
  output logic [3:0]         state
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    EXEC_R   = 4'd3,
    EXEC_I   = 4'd4,
    MEM_ADDR = 4'd5,
    MEM_RD   = 4'd6,
    MEM_WB   = 4'd7,
    MEM_WR   = 4'd8,
    REG_WB   = 4'd9,
    BRANCH   = 4'd10,
    JUMP     = 4'd11,
    TRAP     = 4'd12
  } state_t;

  // Decoded per-state controls; fetch marks the ready-qualified IRWrite/PCWrite.
  typedef struct packed {
    logic               pc_write;
    logic               fetch;
    logic               pc_write_cond;
    logic               iord;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
    logic               reg_dst;
    logic               reg_write;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [1:0]         pc_source;
    logic [ALUOP_W-1:0] alu_op;
  } ctrl_t;

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(6'b001010);
  localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(6'b001100);
  localparam logic [OP_W-1:0] OP_ORI   = OP_W'(6'b001101);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);

  localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(3'b000);
  localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(3'b010);
  localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(3'b110);
  localparam logic [ALUOP_W-1:0] ALU_AND   = ALUOP_W'(3'b011);
  localparam logic [ALUOP_W-1:0] ALU_OR    = ALUOP_W'(3'b001);
  localparam logic [ALUOP_W-1:0] ALU_SLT   = ALUOP_W'(3'b111);

  localparam int              CNT_W     = 16;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_WAIT_MAX - 1);

  state_t            state_q;
  state_t            state_n;
  ctrl_t             ctrl_q;
  logic [CNT_W-1:0]  wait_cnt;
  logic              waiting;
  logic              timeout_hit;
  logic              unused_zero;

  // Branch resolution happens in the datapath (PCWriteCond & zero).
  assign unused_zero = zero;

  function automatic ctrl_t decode_ctrl(input state_t s, input logic [OP_W-1:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.fetch     = 1'b1;
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
        c.alu_op    = ALU_ADD;
      end
      DECODE: begin
        c.alu_src_b = 2'b11;
        c.alu_op    = ALU_ADD;
      end
      EXEC_R: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = ALU_FUNCT;
      end
      EXEC_I: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        case (op)
          OP_SLTI: c.alu_op = ALU_SLT;
          OP_ANDI: c.alu_op = ALU_AND;
          OP_ORI:  c.alu_op = ALU_OR;
          default: c.alu_op = ALU_ADD;
        endcase
      end
      REG_WB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = (op == OP_RTYPE);
      end
      MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_op    = ALU_ADD;
      end
      MEM_RD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      MEM_WR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = ALU_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
      end
      JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b10;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  assign waiting = ((state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR))
                   && !mem_ready;

  always_comb begin
    state_n     = state_q;
    timeout_hit = 1'b0;
    case (state_q)
      IDLE:     state_n = FETCH;
      FETCH:    if (mem_ready) state_n = DECODE;
      DECODE: begin
        case (opCode)
          OP_RTYPE:                          state_n = EXEC_R;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_n = EXEC_I;
          OP_LW, OP_SW:                      state_n = MEM_ADDR;
          OP_BEQ:                            state_n = BRANCH;
          OP_J:                              state_n = JUMP;
          default:                           state_n = TRAP;
        endcase
      end
      EXEC_R, EXEC_I: state_n = REG_WB;
      MEM_ADDR: state_n = (opCode == OP_LW) ? MEM_RD : MEM_WR;
      MEM_RD:   if (mem_ready) state_n = MEM_WB;
      MEM_WR:   if (mem_ready) state_n = FETCH;
      MEM_WB, REG_WB, BRANCH, JUMP: state_n = FETCH;
      TRAP:     state_n = TRAP;
      default:  state_n = IDLE;
    endcase
    // The final wait cycle diverts to TRAP instead of counting further.
    if (waiting && (MEM_WAIT_MAX != 0) && (wait_cnt == WAIT_LAST)) begin
      state_n     = TRAP;
      timeout_hit = 1'b1;
    end
  end

  // Controls are registered alongside the state so they change only at edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ctrl_q      <= '0;
      wait_cnt    <= '0;
      illegal_op  <= 1'b0;
      mem_timeout <= 1'b0;
    end else if (!stall) begin
      state_q <= state_n;
      ctrl_q  <= decode_ctrl(state_n, opCode);
      if (waiting && (state_n == state_q)) wait_cnt <= wait_cnt + CNT_W'(1);
      else                                 wait_cnt <= '0;
      if (timeout_hit) mem_timeout <= 1'b1;
      if ((state_q == DECODE) && (state_n == TRAP)) illegal_op <= 1'b1;
    end
  end

  // Stall masks every read/write enable; mux selects pass through untouched.
  assign PCWrite     = !stall && (ctrl_q.pc_write || (ctrl_q.fetch && mem_ready));
  assign IRWrite     = !stall && ctrl_q.fetch && mem_ready;
  assign PCWriteCond = !stall && ctrl_q.pc_write_cond;
  assign MemRead     = !stall && ctrl_q.mem_read;
  assign MemWrite    = !stall && ctrl_q.mem_write;
  assign RegWrite    = !stall && ctrl_q.reg_write;
  assign IorD        = ctrl_q.iord;
  assign MemToReg    = ctrl_q.mem_to_reg;
  assign RegDst      = ctrl_q.reg_dst;
  assign ALUSrcA     = ctrl_q.alu_src_a;
  assign ALUSrcB     = ctrl_q.alu_src_b;
  assign PCSource    = ctrl_q.pc_source;
  assign ALUOP       = ctrl_q.alu_op;
  assign state       = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: each driven cycle pushes the expected
// output vector; a negedge monitor pops and compares.
module tb_mc_control_fsm;
  localparam int W = 23;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opCode = 6'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       stall = 1'b0;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemToReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCSource;
  logic [2:0] ALUOP;
  logic       illegal_op, mem_timeout;
  logic [3:0] state;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] msk_q[$];
  int           tag_q[$];
  int           checks = 0;
  int           failures = 0;
  int           step = 0;

  mc_control_fsm #(.OP_W(6), .ALUOP_W(3), .MEM_WAIT_MAX(15)) dut (
    .clk(clk), .rst(rst), .opCode(opCode), .zero(zero), .mem_ready(mem_ready),
    .stall(stall), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemToReg(MemToReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALUOP(ALUOP),
    .illegal_op(illegal_op), .mem_timeout(mem_timeout), .state(state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // en bits: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemToReg RegDst RegWrite ALUSrcA
  function automatic logic [W-1:0] ex(input logic [3:0] st, input logic [9:0] en,
                                      input logic [1:0] sb, input logic [1:0] ps,
                                      input logic [2:0] op, input logic ill, input logic to);
    return {st, en, sb, ps, op, ill, to};
  endfunction

  // driver: after an edge, apply next inputs and queue the outputs expected now
  task automatic cyc(input logic r, input logic s, input logic m, input logic [5:0] op,
                     input logic [W-1:0] e, input logic [W-1:0] msk = '1);
    @(posedge clk);
    #1;
    rst = r; stall = s; mem_ready = m; opCode = op;
    step++;
    exp_q.push_back(e);
    msk_q.push_back(msk);
    tag_q.push_back(step);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e, m, got;
      int t;
      e = exp_q.pop_front();
      m = msk_q.pop_front();
      t = tag_q.pop_front();
      got = {state, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemToReg,
             RegDst, RegWrite, ALUSrcA, ALUSrcB, PCSource, ALUOP, illegal_op, mem_timeout};
      checks++;
      if ((got & m) !== (e & m)) begin
        failures++;
        $display("FAIL step%0d outputs: got=%h expected=%h (state got %0d exp %0d)",
                 t, got & m, e & m, got[22:19], e[22:19]);
      end
    end
  end

  logic [W-1:0] IDLE_V, FETCH_V, FETCH_W, FETCH_S, DEC_V, EXR_V, RWB_R, RWB_I;
  logic [W-1:0] MADR_V, MRD_V, MWB_V, MWR_V, BR_V, J_V, ORI_V, SLTI_V, TRAP_V, TMO_V;
  logic [W-1:0] NO_ILL;

  initial begin
    IDLE_V  = ex(4'd0,  10'b0000000000, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0);
    FETCH_V = ex(4'd1,  10'b1001010000, 2'b01, 2'b00, 3'b010, 1'b0, 1'b0);
    FETCH_W = ex(4'd1,  10'b0001000000, 2'b01, 2'b00, 3'b010, 1'b0, 1'b0);
    FETCH_S = ex(4'd1,  10'b0000000000, 2'b01, 2'b00, 3'b010, 1'b0, 1'b0);
    DEC_V   = ex(4'd2,  10'b0000000000, 2'b11, 2'b00, 3'b010, 1'b0, 1'b0);
    EXR_V   = ex(4'd3,  10'b0000000001, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0);
    RWB_R   = ex(4'd9,  10'b0000000110, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0);
    RWB_I   = ex(4'd9,  10'b0000000010, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0);
    MADR_V  = ex(4'd5,  10'b0000000001, 2'b10, 2'b00, 3'b010, 1'b0, 1'b0);
    MRD_V   = ex(4'd6,  10'b0011000000, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0);
    MWB_V   = ex(4'd7,  10'b0000001010, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0);
    MWR_V   = ex(4'd8,  10'b0010100000, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0);
    BR_V    = ex(4'd10, 10'b0100000001, 2'b00, 2'b01, 3'b110, 1'b0, 1'b0);
    J_V     = ex(4'd11, 10'b1000000000, 2'b00, 2'b10, 3'b000, 1'b0, 1'b0);
    ORI_V   = ex(4'd4,  10'b0000000001, 2'b10, 2'b00, 3'b001, 1'b0, 1'b0);
    SLTI_V  = ex(4'd4,  10'b0000000001, 2'b10, 2'b00, 3'b111, 1'b0, 1'b0);
    TRAP_V  = ex(4'd12, 10'b0000000000, 2'b00, 2'b00, 3'b000, 1'b1, 1'b0);
    TMO_V   = ex(4'd12, 10'b0000000000, 2'b00, 2'b00, 3'b000, 1'b0, 1'b1);
    NO_ILL  = ~(23'b10);

    // reset two cycles, then R-type
    cyc(1, 0, 0, 6'b000000, IDLE_V);
    cyc(0, 0, 1, 6'b000000, IDLE_V);
    cyc(0, 0, 1, 6'b000000, FETCH_V);
    cyc(0, 0, 1, 6'b000000, DEC_V);
    cyc(0, 0, 1, 6'b000000, EXR_V);
    cyc(0, 0, 1, 6'b000000, RWB_R);
    // LW with three not-ready cycles in MEM_RD
    cyc(0, 0, 1, 6'b100011, FETCH_V);
    cyc(0, 0, 1, 6'b100011, DEC_V);
    cyc(0, 0, 0, 6'b100011, MADR_V);
    cyc(0, 0, 0, 6'b100011, MRD_V);
    cyc(0, 0, 0, 6'b100011, MRD_V);
    cyc(0, 0, 0, 6'b100011, MRD_V);
    cyc(0, 0, 1, 6'b100011, MRD_V);
    cyc(0, 0, 1, 6'b100011, MWB_V);
    // BEQ
    cyc(0, 0, 1, 6'b000100, FETCH_V);
    cyc(0, 0, 1, 6'b000100, DEC_V);
    cyc(0, 0, 1, 6'b000100, BR_V);
    // J
    cyc(0, 0, 1, 6'b000010, FETCH_V);
    cyc(0, 0, 1, 6'b000010, DEC_V);
    cyc(0, 0, 1, 6'b000010, J_V);
    // SW, ready immediately
    cyc(0, 0, 1, 6'b101011, FETCH_V);
    cyc(0, 0, 1, 6'b101011, DEC_V);
    cyc(0, 0, 1, 6'b101011, MADR_V);
    cyc(0, 0, 1, 6'b101011, MWR_V);
    // ORI stalled two cycles in EXEC_I, reset in REG_WB
    cyc(0, 0, 1, 6'b001101, FETCH_V);
    cyc(0, 0, 1, 6'b001101, DEC_V);
    cyc(0, 1, 1, 6'b001101, ORI_V);
    cyc(0, 1, 1, 6'b001101, ORI_V);
    cyc(0, 0, 1, 6'b001101, ORI_V);
    cyc(1, 0, 1, 6'b001101, RWB_I);
    cyc(0, 0, 1, 6'b001101, IDLE_V);
    // stall in FETCH masks enables even with mem_ready high
    cyc(0, 1, 1, 6'b111111, FETCH_S);
    cyc(0, 0, 1, 6'b111111, FETCH_V);
    // illegal opcode trap, sticky until reset
    cyc(0, 0, 1, 6'b111111, DEC_V);
    cyc(0, 0, 1, 6'b000000, TRAP_V);
    cyc(1, 0, 1, 6'b000000, TRAP_V);
    cyc(0, 0, 0, 6'b000000, IDLE_V);
    // fetch timeout after 15 not-ready cycles
    for (int i = 0; i < 15; i++) cyc(0, 0, 0, 6'b000000, FETCH_W);
    cyc(0, 0, 1, 6'b000000, TMO_V, NO_ILL);
    cyc(1, 0, 1, 6'b000000, TMO_V, NO_ILL);
    // SLTI after reset clears flags
    cyc(0, 0, 1, 6'b001010, IDLE_V);
    cyc(0, 0, 1, 6'b001010, FETCH_V);
    cyc(0, 0, 1, 6'b001010, DEC_V);
    cyc(0, 0, 1, 6'b001010, SLTI_V);
    cyc(0, 0, 1, 6'b001010, RWB_I);
    cyc(0, 0, 1, 6'b001010, FETCH_V);

    repeat (3) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
